// File: rtl/key_debounce_array.sv
// key_debounce_array: synchronise, debounce and auto-repeat N push-button channels with a press encoder
module key_debounce_array #(
    parameter int N_KEYS        = 3,
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16,
    parameter int CODE_W        = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic [N_KEYS-1:0] repeat_en,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_multi
);
    localparam int CW   = $clog2(STABLE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    logic [N_KEYS-1:0] sync1, sync;
    // two-flop synchroniser for the asynchronous key pins
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= '0;
            sync  <= '0;
        end else begin
            sync1 <= key_raw;
            sync  <= sync1;
        end
    end
    genvar k;
    generate
        for (k = 0; k < N_KEYS; k++) begin : g_key
            logic [CW-1:0] cnt;
            logic [RW-1:0] rcnt;
            logic          rep, lvl, prs, rls;
            logic          flip, active, tick;
            assign flip   = (sync[k] != lvl) && (cnt == CW'(STABLE_CYCLES - 1));
            assign active = lvl && repeat_en[k] && !flip;
            assign tick   = active && (rcnt == (rep ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1)));
            assign key_level[k]   = lvl;
            assign key_press[k]   = prs;
            assign key_release[k] = rls;
            // stable-count debounce, edge pulses and auto-repeat timer for one key
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    cnt  <= '0;
                    rcnt <= '0;
                    rep  <= 1'b0;
                    lvl  <= 1'b0;
                    prs  <= 1'b0;
                    rls  <= 1'b0;
                end else begin
                    cnt <= (sync[k] == lvl || flip) ? '0 : cnt + CW'(1);
                    if (flip)
                        lvl <= sync[k];
                    prs <= (flip && sync[k]) || tick;
                    rls <= flip && !sync[k];
                    if (!active) begin
                        rcnt <= '0;
                        rep  <= 1'b0;
                    end else if (tick) begin
                        rcnt <= '0;
                        rep  <= 1'b1;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
                end
            end
        end
    endgenerate
    // priority encoder straight off the press flops: lowest index wins
    always_comb begin
        key_code = '0;
        for (int i = N_KEYS - 1; i >= 0; i--)
            if (key_press[i])
                key_code = CODE_W'(i);
        key_valid = |key_press;
        key_multi = |(key_press & (key_press - N_KEYS'(1)));
    end
endmodule
